// File: rtl/latch_wr_sched.sv
// Write-port scheduler for a bank of level-sensitive latches: round-robin
// arbitration between two requesters, then a SETUP -> PULSE -> HOLD enable sequence.
module latch_wr_sched #(
    parameter int NUM_ENTRY = 8,
    parameter int AW        = 3,
    parameter int DW        = 8,
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 1,
    parameter int HOLD_CYC  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0_valid,
    input  logic [AW-1:0]        req0_addr,
    input  logic [DW-1:0]        req0_data,
    output logic                 req0_ready,
    input  logic                 req1_valid,
    input  logic [AW-1:0]        req1_addr,
    input  logic [DW-1:0]        req1_data,
    output logic                 req1_ready,
    output logic [NUM_ENTRY-1:0] lat_en,
    output logic [DW-1:0]        lat_data,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic                 grant_id
);

    localparam int MAXSP = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int MAXC  = (MAXSP > HOLD_CYC) ? MAXSP : HOLD_CYC;
    localparam int CW    = $clog2(MAXC + 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        PULSE,
        HOLD
    } state_t;

    state_t               state;
    logic [CW-1:0]        cnt;
    logic                 rr;
    logic [AW-1:0]        cap_addr;
    logic                 cap_oor;

    logic                 any_valid;
    logic                 win;
    logic [AW-1:0]        win_addr;
    logic [DW-1:0]        win_data;
    logic                 win_oor;
    logic [NUM_ENTRY-1:0] onehot;

    // Arbitration: a lone requester always wins; on contention the rr pointer decides.
    always_comb begin
        any_valid = req0_valid | req1_valid;
        win       = 1'b0;
        if (req0_valid && req1_valid) begin
            win = rr;
        end else begin
            win = req1_valid;
        end
        win_addr   = win ? req1_addr : req0_addr;
        win_data   = win ? req1_data : req0_data;
        win_oor    = 32'(win_addr) >= 32'(NUM_ENTRY);
        req0_ready = (state == IDLE) && req0_valid && !win;
        req1_ready = (state == IDLE) && req1_valid && win;
    end

    // Out-of-range captured addresses decode to all-zero, so no latch ever opens.
    always_comb begin
        onehot = '0;
        for (int unsigned i = 0; i < NUM_ENTRY; i++) begin
            onehot[i] = (32'(cap_addr) == i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            rr       <= 1'b0;
            cap_addr <= '0;
            cap_oor  <= 1'b0;
            lat_en   <= '0;
            lat_data <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            grant_id <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        cap_addr <= win_addr;
                        cap_oor  <= win_oor;
                        lat_data <= win_data;
                        grant_id <= win;
                        rr       <= ~win;
                        busy     <= 1'b1;
                        cnt      <= '0;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt == CW'(SETUP_CYC - 1)) begin
                        cnt    <= '0;
                        lat_en <= onehot;
                        state  <= PULSE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PULSE: begin
                    if (cnt == CW'(PULSE_CYC - 1)) begin
                        cnt    <= '0;
                        lat_en <= '0;
                        state  <= HOLD;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (cnt == CW'(HOLD_CYC - 1)) begin
                        cnt   <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        err   <= cap_oor;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    lat_en <= '0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule
